// File: rtl/kovacs_noise_scaler.sv
// Three-stage noise conditioning pipeline: offset removal, dual gain, floor shift
// and saturation, producing time-aligned full / rescaled / low streams.
module kovacs_noise_scaler #(
  parameter int SHIFT  = 15,
  parameter int GAIN_W = 16
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic signed [15:0]       data_i,
  input  logic                     valid_i,
  input  logic signed [15:0]       offset_i,
  input  logic        [GAIN_W-1:0] gain_rescaled_i,
  input  logic        [GAIN_W-1:0] gain_low_i,
  input  logic                     update_i,
  input  logic                     clear_i,
  output logic signed [15:0]       data_o,
  output logic signed [15:0]       data_rescaled_o,
  output logic signed [15:0]       data_low_o,
  output logic                     valid_o,
  output logic        [2:0]        sat_o
);

  localparam int PW = 17 + GAIN_W;
  localparam logic [GAIN_W-1:0] UNITY = {{(GAIN_W-1){1'b0}}, 1'b1} << SHIFT;

  // Floor-shift a product and clamp it to 16-bit signed; bit 16 flags a clamp.
  function automatic logic [16:0] shift_sat(input logic signed [PW-1:0] p);
    logic signed [PW-1:0] s;
    s = p >>> SHIFT;
    if (s[PW-1:15] == '0 || s[PW-1:15] == '1)
      return {1'b0, s[15:0]};
    else
      return {1'b1, s[PW-1] ? 16'h8000 : 16'h7fff};
  endfunction

  logic signed [15:0]       offset;
  logic        [GAIN_W-1:0] gain_r;
  logic        [GAIN_W-1:0] gain_l;

  logic signed [16:0]       diff;
  logic                     diff_ovf;
  logic signed [15:0]       diff_sat;

  logic signed [15:0]       d1;
  logic        [GAIN_W-1:0] g_r1;
  logic        [GAIN_W-1:0] g_l1;
  logic                     v1;
  logic                     s0_1;

  logic signed [PW-1:0]     d1_ext;
  logic signed [PW-1:0]     g_r1_ext;
  logic signed [PW-1:0]     g_l1_ext;

  logic signed [15:0]       d2;
  logic signed [PW-1:0]     p_r2;
  logic signed [PW-1:0]     p_l2;
  logic                     v2;
  logic                     s0_2;

  logic [16:0]              res_r;
  logic [16:0]              res_l;

  always_comb begin
    diff     = {data_i[15], data_i} - {offset[15], offset};
    diff_ovf = diff[16] ^ diff[15];
    diff_sat = diff_ovf ? (diff[16] ? 16'sh8000 : 16'sh7fff) : diff[15:0];
  end

  // Gains are zero-extended so a full-scale gain stays positive.
  assign d1_ext   = {{(PW-16){d1[15]}}, d1};
  assign g_r1_ext = {{(PW-GAIN_W){1'b0}}, g_r1};
  assign g_l1_ext = {{(PW-GAIN_W){1'b0}}, g_l1};

  assign res_r = shift_sat(p_r2);
  assign res_l = shift_sat(p_l2);

  // NOTE: non-blocking assignments throughout so every stage samples the
  // previous stage's value from before this edge; the reset also clears the
  // pipeline data so nothing half-processed emerges after a mid-stream reset.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      offset          <= '0;
      gain_r          <= UNITY;
      gain_l          <= UNITY;
      d1              <= '0;
      g_r1            <= UNITY;
      g_l1            <= UNITY;
      v1              <= 1'b0;
      s0_1            <= 1'b0;
      d2              <= '0;
      p_r2            <= '0;
      p_l2            <= '0;
      v2              <= 1'b0;
      s0_2            <= 1'b0;
      data_o          <= '0;
      data_rescaled_o <= '0;
      data_low_o      <= '0;
      valid_o         <= 1'b0;
      sat_o           <= '0;
    end else begin
      if (update_i) begin
        offset <= offset_i;
        gain_r <= gain_rescaled_i;
        gain_l <= gain_low_i;
      end

      // Stage 1 uses and captures the set active before this edge's update.
      d1   <= diff_sat;
      g_r1 <= gain_r;
      g_l1 <= gain_l;
      v1   <= valid_i;
      s0_1 <= valid_i & diff_ovf;

      d2   <= d1;
      p_r2 <= d1_ext * g_r1_ext;
      p_l2 <= d1_ext * g_l1_ext;
      v2   <= v1;
      s0_2 <= s0_1;

      data_o          <= d2;
      data_rescaled_o <= res_r[15:0];
      data_low_o      <= res_l[15:0];
      valid_o         <= v2;
      // A saturation event on the clearing edge wins over the clear.
      sat_o <= (clear_i ? 3'b000 : sat_o)
             | {v2 & res_l[16], v2 & res_r[16], v2 & s0_2};
    end
  end

endmodule

// File: tb/tb_kovacs_noise_scaler.sv
// Table-driven bench for kovacs_noise_scaler with a latency-aligned scoreboard
// queue and a small sticky-flag tracker.
module tb_kovacs_noise_scaler;

  localparam int U = 32768;

  logic               clk_i = 1'b0;
  logic               rstn_i;
  logic signed [15:0] data_i;
  logic               valid_i;
  logic signed [15:0] offset_i;
  logic        [15:0] gain_rescaled_i;
  logic        [15:0] gain_low_i;
  logic               update_i;
  logic               clear_i;
  logic signed [15:0] data_o;
  logic signed [15:0] data_rescaled_o;
  logic signed [15:0] data_low_o;
  logic               valid_o;
  logic        [2:0]  sat_o;

  kovacs_noise_scaler #(.SHIFT(15), .GAIN_W(16)) dut (
    .clk_i           (clk_i),
    .rstn_i          (rstn_i),
    .data_i          (data_i),
    .valid_i         (valid_i),
    .offset_i        (offset_i),
    .gain_rescaled_i (gain_rescaled_i),
    .gain_low_i      (gain_low_i),
    .update_i        (update_i),
    .clear_i         (clear_i),
    .data_o          (data_o),
    .data_rescaled_o (data_rescaled_o),
    .data_low_o      (data_low_o),
    .valid_o         (valid_o),
    .sat_o           (sat_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic signed [15:0] data;
    logic               valid;
    logic signed [15:0] offset;
    logic        [15:0] g_r;
    logic        [15:0] g_l;
    logic               update;
    logic               clear;
    logic signed [15:0] e_data;
    logic signed [15:0] e_resc;
    logic signed [15:0] e_low;
    logic        [2:0]  e_s;
  } vec_t;

  typedef struct {
    logic               chk;
    logic               valid;
    logic signed [15:0] data;
    logic signed [15:0] resc;
    logic signed [15:0] low;
    logic        [2:0]  s;
  } exp_t;

  int         tests  = 0;
  int         failed = 0;
  logic [2:0] sat_exp = '0;
  exp_t       sb[$];
  vec_t       tbl[$];

  function automatic vec_t mk(input int d, input int v, input int off, input int gr,
                              input int gl, input int upd, input int clr, input int ed,
                              input int er, input int el, input int es);
    vec_t r;
    r.data   = 16'(d);
    r.valid  = v[0];
    r.offset = 16'(off);
    r.g_r    = 16'(gr);
    r.g_l    = 16'(gl);
    r.update = upd[0];
    r.clear  = clr[0];
    r.e_data = 16'(ed);
    r.e_resc = 16'(er);
    r.e_low  = 16'(el);
    r.e_s    = 3'(es);
    return r;
  endfunction

  function automatic vec_t idle(input int clr);
    return mk(0, 0, 0, 0, 0, 0, clr, 0, 0, 0, 0);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_zero();
    exp_t z;
    z.chk = 1'b1; z.valid = 1'b0; z.data = '0; z.resc = '0; z.low = '0; z.s = '0;
    sb.push_back(z);
  endtask

  task automatic step(input vec_t v, input string tag);
    exp_t e;
    data_i          = v.data;
    valid_i         = v.valid;
    offset_i        = v.offset;
    gain_rescaled_i = v.g_r;
    gain_low_i      = v.g_l;
    update_i        = v.update;
    clear_i         = v.clear;
    e.chk   = v.valid;
    e.valid = v.valid;
    e.data  = v.e_data;
    e.resc  = v.e_resc;
    e.low   = v.e_low;
    e.s     = v.valid ? v.e_s : 3'b000;
    sb.push_back(e);
    @(posedge clk_i);
    @(negedge clk_i);
    if (sb.size() == 3) begin
      e = sb.pop_front();
      sat_exp = (v.clear ? 3'b000 : sat_exp) | e.s;
      check({tag, " valid"}, int'(valid_o), int'(e.valid));
      check({tag, " sat"}, int'(sat_o), int'(sat_exp));
      if (e.chk) begin
        check({tag, " data"}, int'(data_o), int'(e.data));
        check({tag, " resc"}, int'(data_rescaled_o), int'(e.resc));
        check({tag, " low"}, int'(data_low_o), int'(e.low));
      end
    end else begin
      check({tag, " scoreboard depth"}, sb.size(), 3);
    end
  endtask

  task automatic do_reset(input string tag);
    rstn_i = 1'b0; valid_i = 1'b0; update_i = 1'b0; clear_i = 1'b0; data_i = 16'sd1234;
    @(posedge clk_i);
    @(negedge clk_i);
    check({tag, " data"}, int'(data_o), 0);
    check({tag, " resc"}, int'(data_rescaled_o), 0);
    check({tag, " low"}, int'(data_low_o), 0);
    check({tag, " valid"}, int'(valid_o), 0);
    check({tag, " sat"}, int'(sat_o), 0);
    rstn_i = 1'b1;
    sb.delete();
    push_zero();
    push_zero();
    sat_exp = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    // Directed rows; each sample's expected outputs appear three edges later.
    tbl.push_back(mk(1000, 1, 0, U, U, 0, 0, 1000, 1000, 1000, 0));
    tbl.push_back(mk(-1001, 1, 0, 16384, 8192, 1, 0, -1001, -1001, -1001, 0));
    tbl.push_back(mk(-1001, 1, 5, 1, 1, 0, 0, -1001, -501, -251, 0));
    tbl.push_back(idle(0));
    tbl.push_back(mk(100, 1, -32768, U, U, 1, 0, 100, 50, 25, 0));
    tbl.push_back(mk(100, 1, 0, 0, 0, 0, 0, 32767, 32767, 32767, 3'b001));
    tbl.push_back(idle(0));
    tbl.push_back(idle(0));
    tbl.push_back(idle(1));
    tbl.push_back(mk(0, 0, 0, 65535, U, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(20000, 1, 0, 0, 0, 0, 0, 20000, 32767, 20000, 3'b010));
    tbl.push_back(mk(20000, 1, 0, 0, 0, 0, 0, 20000, 32767, 20000, 3'b010));
    tbl.push_back(idle(0));
    tbl.push_back(idle(1));
    tbl.push_back(idle(0));
    tbl.push_back(idle(1));
    tbl.push_back(mk(0, 0, 0, 0, 65535, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(-32768, 1, 0, 0, 0, 0, 0, -32768, 0, -32768, 3'b100));
    tbl.push_back(mk(32767, 1, 0, 0, 0, 0, 0, 32767, 0, 32767, 3'b100));
    tbl.push_back(mk(-32768, 1, 1, U, U, 1, 0, -32768, 0, -32768, 3'b100));
    tbl.push_back(mk(-32768, 1, 0, 0, 0, 0, 0, -32768, -32768, -32768, 3'b001));
    tbl.push_back(mk(0, 0, 0, U, U, 1, 0, 0, 0, 0, 0));

    rstn_i = 1'b0; data_i = '0; valid_i = 1'b0; offset_i = '0;
    gain_rescaled_i = '0; gain_low_i = '0; update_i = 1'b0; clear_i = 1'b0;
    @(negedge clk_i);
    do_reset("reset");

    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i], $sformatf("row%0d", i));

    // Ramp: gain_low halves starting at sample 20; update rides on sample 19.
    for (int n = 0; n < 45; n++) begin
      int gl;
      gl = (n >= 19) ? 16384 : U;
      step(mk(n, 1, 0, U, gl, (n == 19) ? 1 : 0, 0, n, n, (n < 20) ? n : (n >> 1), 0),
           $sformatf("ramp%0d", n));
    end

    do_reset("mid reset");
    step(mk(1000, 1, 123, 7, 9, 0, 0, 1000, 1000, 1000, 0), "post0");
    for (int i = 1; i < 4; i++)
      step(idle(0), $sformatf("post%0d", i));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/kovacs_noise_scaler.md
Name: kovacs_noise_scaler

Overview:
- Upstream stage of the Kovacs protocol switch. It takes one 16-bit signed noise stream and produces three time-aligned 16-bit streams: full, rescaled and low.
- These outputs drive the switch's data_i, data_rescaled_i and data_low_i inputs directly.
- Processing: offset removal, two independent gain multiplies, arithmetic shift, saturation, valid tracking, sticky saturation flags.
- Gain and offset changes take effect atomically on an update strobe, so all three streams always use one consistent coefficient set.

Parameters:
- SHIFT, 15: right-shift applied to each gain product; gain value 2^SHIFT is unity.
- GAIN_W, 16: width of the unsigned gain inputs.

Ports:
- clk_i  in  1  system clock; all logic on rising edge.
- rstn_i  in  1  synchronous reset, active-low.
- data_i  in  16  signed input sample.
- valid_i  in  1  data_i qualifier.
- offset_i  in  16  signed offset subtracted from data_i.
- gain_rescaled_i  in  GAIN_W  unsigned gain for the rescaled stream.
- gain_low_i  in  GAIN_W  unsigned gain for the low stream.
- update_i  in  1  single-cycle strobe; latches offset_i and both gains into the active registers.
- clear_i  in  1  clears the sticky saturation flags.
- data_o  in/out: out  16  offset-corrected full-scale sample (signed).
- data_rescaled_o  out  16  rescaled sample (signed).
- data_low_o  out  16  low sample (signed).
- valid_o  out  1  qualifier for all three data outputs.
- sat_o  out  3  sticky saturation flags: [0] offset stage, [1] rescaled stream, [2] low stream.

Behaviour:
- Reset (rstn_i=0 at a clock edge):
  - all data outputs = 0, valid_o = 0, sat_o = 0;
  - active offset = 0, active gains = 2^SHIFT (unity);
  - pipeline contents discarded; valid pipeline cleared.
  - Reset mid-stream: no partially processed sample emerges afterwards.
- Coefficient update:
  - On a rising edge with update_i=1, active offset and gains load the input values.
  - The sample entering stage 1 on that same edge still uses the old set.
  - Samples entering on later edges use the new set.
  - The three streams never mix sets for one sample.
  - update_i held high reloads every cycle.
  - With update_i=0, input changes on offset_i and the gain inputs have no effect.
- Pipeline (fixed latency 3 cycles, stalls never occur):
  - Stage 1: d1 = sat16(data_i - offset), computed in 17-bit signed. Clamp to 32767 or -32768; a clamp sets flag s0 for that sample. The gains active at this edge are captured alongside d1.
  - Stage 2: p_r = d1 * gain_rescaled and p_l = d1 * gain_low. Products are signed, 17+GAIN_W bits, with the gain zero-extended. d1 is delayed one stage.
  - Stage 3: arithmetic shift right by SHIFT, which truncates toward minus infinity. Then saturate to 16-bit signed and register into the outputs. data_o = d1 delayed to stay aligned.
- Valid handling:
  - valid_i is delayed 3 cycles to valid_o.
  - Data registers update every cycle regardless of valid_i.
  - Saturation flags set only for samples that are valid at their stage.
- Sticky flags:
  - A flag bit goes to 1 on the cycle its sample reaches the output (stage 3) with saturation detected. The stage-1 flag is piped along with the sample.
  - clear_i=1 zeroes sat_o on the next edge.
  - If clear_i and a new saturation event occur on the same edge, the set wins and the bit reads 1.
- Gain limits:
  - Gain 0 gives output 0.
  - Gain 2^GAIN_W-1 is about 2x with SHIFT=15. Saturation then protects the downstream 14-bit truncation.

Test Plan:
- Reset, then valid_i=1, data_i=1000, defaults in place -> after 3 cycles: data_o=1000, data_rescaled_o=1000, data_low_o=1000, valid_o=1, sat_o=0.
- update_i pulse with gain_rescaled=16384, gain_low=8192, offset=0; data_i=-1001 -> data_o=-1001, rescaled=-501, low=-251 (floor shift).
- offset_i=-32768 loaded via update_i, data_i=100 -> data_o=32767, sat_o[0]=1. Then clear_i with no new event -> sat_o=0.
- gain_rescaled=65535 (update_i), data_i=20000 -> rescaled=32767, sat_o[1]=1. Also apply clear_i on the same edge as a further saturated sample -> sat_o[1] stays 1.
- Continuous ramp 0,1,2,… with update_i changing gain_low from 32768 to 16384 at sample k -> samples <k give low=n, samples ≥k give low=n>>1. No sample mixes sets.
- Drop rstn_i low for 1 cycle mid-ramp -> next edge: outputs 0, valid_o=0 for 3 cycles after release, gains back to unity.
